clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider and tick generator; the parametrised successor to the team's fixed 50 MHz → 1 Hz divider.
- Each of CHANNELS independent channels divides clock_50MHZ by a runtime-loadable divisor.
- Each channel has a per-channel enable and a selectable output mode: 50% toggle clock, or one-cycle pulse.
- Feeds LED blinkers, counters and debouncers that need slow enables derived from the board clock.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- WIDTH, 26, divisor/counter width in bits.
- SEL_W, 2, width of load_sel; must satisfy 2^SEL_W >= CHANNELS.
- DEFAULT_DIV, 26'h2FAF080, divisor value D loaded into every channel at reset (50,000,000).
- DEFAULT_MODE, 0, mode loaded at reset (0 = toggle, 1 = pulse).

Ports:
- clock_50MHZ  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  CHANNELS  per-channel run enable, level-sensitive.
- load  input  1  one-cycle strobe: write load_value/load_mode into channel load_sel.
- load_sel  input  SEL_W  target channel index for load.
- load_value  input  WIDTH  new divisor D.
- load_mode  input  1  new mode (0 toggle, 1 pulse).
- newClock  output  CHANNELS  divided output per channel, registered.
- tick  output  CHANNELS  one-cycle pulse at each terminal count, registered.

Behaviour:
- Reset (reset_n low, asynchronous): every counter = 0, div_reg = DEFAULT_DIV, mode_reg = DEFAULT_MODE, newClock = 0, tick = 0. Release is synchronous to the next rising edge.
- Per channel i, each rising edge, in priority order:
  1. load && load_sel == i: div_reg <= load_value, mode_reg <= load_mode, counter <= 0, newClock[i] <= 0, tick[i] <= 0. This applies regardless of enable[i].
  2. else if !enable[i]: counter holds, tick[i] <= 0. Toggle mode: newClock[i] holds. Pulse mode: newClock[i] <= 0.
  3. else if counter == div_reg: counter <= 0, tick[i] <= 1. Toggle mode: newClock[i] <= ~newClock[i]. Pulse mode: newClock[i] <= 1.
  4. else: counter <= counter + 1, tick[i] <= 0. Toggle mode: newClock[i] holds. Pulse mode: newClock[i] <= 0.
- Periods: toggle period = 2*(D+1) cycles at exactly 50% duty; pulse/tick period = D+1 cycles.
- Latency: the first tick is high during the (D+1)th cycle after enable rises with counter = 0, i.e. after D+1 enabled edges.
- D = 0: tick held high continuously; toggle output = clock_50MHZ/2; pulse output held high.
- Counter is WIDTH bits and never exceeds div_reg, because load always clears it. No wrap-around past D; D = 2^WIDTH-1 is legal.
- load_sel >= CHANNELS: load is ignored and no channel changes.
- Load while a channel is enabled: that channel restarts phase-aligned from counter 0 on the next edge. Other channels are unaffected.
- Enable deasserted mid-count: count pauses and resumes from the held value (no restart).
- Mode change takes effect only through load. newClock is cleared on load, so there is no glitch carry-over.
- Reset mid-operation: all channels return immediately to reset state, including div_reg (loaded divisors are lost).
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.

Test Plan:
- Reset, DEFAULT_DIV=3, mode 0, enable=4'b0001 → newClock[0] toggles every 4 cycles (period 8); tick[0] high 1 cycle every 4; channels 1–3 stay 0.
- load=1, load_sel=2, load_value=1, load_mode=1, then enable[2]=1 → newClock[2] = tick[2] = 1 every 2nd cycle; first pulse on the 2nd enabled edge.
- Channel 0 running (D=3, counter=2): drop enable[0] for 5 cycles → counter holds at 2, tick stays 0, newClock holds; re-enable → tick after exactly 2 more edges.
- load_value=0 on channel 1, mode 0, enabled → newClock[1] toggles every cycle, tick[1] constant 1; reload with D=5 mid-run → counter restarts from 0, newClock[1] = 0, next tick 6 edges later.
- load_sel=3 with CHANNELS=3 → no register changes; assert reset_n=0 mid-count → all outputs 0 immediately (before the next edge); after release, every channel has div_reg = DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// =============================================================================
// Module   : clk_div_multi_if
// Brief    : Control/load bus and divided outputs of the multi-channel divider.
// Revision : 1.0 - initial release
// =============================================================================
interface clk_div_multi_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 26,
    parameter int unsigned SEL_W    = 2
);
    logic [CHANNELS-1:0] enable;
    logic                load;
    logic [SEL_W-1:0]    load_sel;
    logic [WIDTH-1:0]    load_value;
    logic                load_mode;
    logic [CHANNELS-1:0] newClock;
    logic [CHANNELS-1:0] tick;

    modport master (
        output enable, load, load_sel, load_value, load_mode,
        input  newClock, tick
    );

    modport slave (
        input  enable, load, load_sel, load_value, load_mode,
        output newClock, tick
    );
endinterface

`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// =============================================================================
// Module   : clk_div_multi
// Brief    : CHANNELS independent runtime-loadable clock dividers / tick gens.
// Revision : 1.0 - initial release
// =============================================================================
module clk_div_multi #(
    parameter int unsigned      CHANNELS     = 4,
    parameter int unsigned      WIDTH        = 26,
    parameter int unsigned      SEL_W        = 2,
    parameter logic [WIDTH-1:0] DEFAULT_DIV  = 26'h2FAF080,
    parameter bit               DEFAULT_MODE = 1'b0
) (
    input  wire logic       clock_50MHZ,
    input  wire logic       reset_n,
    clk_div_multi_if.slave  bus
);

    logic [CHANNELS-1:0] w_new_clock;
    logic [CHANNELS-1:0] w_tick;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam logic [SEL_W-1:0] c_idx = SEL_W'(gi);

        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div;
        logic             r_mode;
        logic             r_clk;
        logic             r_tick;
        logic             w_hit;
        logic             w_terminal;

        // Out-of-range load_sel values match no channel and are dropped.
        assign w_hit      = bus.load && (bus.load_sel == c_idx);
        assign w_terminal = (r_cnt == r_div);

        always_ff @(posedge clock_50MHZ or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_div  <= DEFAULT_DIV;
                r_mode <= DEFAULT_MODE;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_hit) begin
                r_div  <= bus.load_value;
                r_mode <= bus.load_mode;
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (!bus.enable[gi]) begin
                r_tick <= 1'b0;
                if (r_mode) begin
                    r_clk <= 1'b0;
                end
            end else if (w_terminal) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_clk  <= r_mode ? 1'b1 : ~r_clk;
            end else begin
                r_cnt  <= r_cnt + WIDTH'(1);
                r_tick <= 1'b0;
                if (r_mode) begin
                    r_clk <= 1'b0;
                end
            end
        end

        assign w_new_clock[gi] = r_clk;
        assign w_tick[gi]      = r_tick;
    end

    assign bus.newClock = w_new_clock;
    assign bus.tick     = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// =============================================================================
// Module   : tb_clk_div_multi
// Brief    : Directed + randomized bench for clk_div_multi against a period model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_clk_div_multi;

    localparam int unsigned  CH    = 3;
    localparam int unsigned  W     = 8;
    localparam int unsigned  SW    = 2;
    localparam logic [W-1:0] DDIV  = 8'd3;
    localparam bit           DMODE = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_div_multi_if #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW)) bus ();

    clk_div_multi #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .SEL_W       (SW),
        .DEFAULT_DIV (DDIV),
        .DEFAULT_MODE(DMODE)
    ) dut (
        .clock_50MHZ(clk),
        .reset_n    (rst_n),
        .bus        (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: a channel's outputs follow from how many enabled edges it has
    // seen since its last load/reset (m_k) and whether the latest edge was one.
    int     m_div  [CH];
    bit     m_mode [CH];
    longint m_k    [CH];
    bit     m_live [CH];

    function automatic logic [CH-1:0] exp_tick();
        logic [CH-1:0] t;
        for (int c = 0; c < CH; c++)
            t[c] = m_live[c] && ((m_k[c] % longint'(m_div[c] + 1)) == 0);
        return t;
    endfunction

    function automatic logic [CH-1:0] exp_clk();
        logic [CH-1:0] t;
        logic [CH-1:0] k;
        t = exp_tick();
        for (int c = 0; c < CH; c++)
            k[c] = m_mode[c] ? t[c] : (((m_k[c] / longint'(m_div[c] + 1)) % 2) == 1);
        return k;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_div[c]  = int'(DDIV);
            m_mode[c] = DMODE;
            m_k[c]    = 0;
            m_live[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            if (bus.load && (int'(bus.load_sel) == c)) begin
                m_div[c]  = int'(bus.load_value);
                m_mode[c] = bus.load_mode;
                m_k[c]    = 0;
                m_live[c] = 1'b0;
            end else if (!bus.enable[c]) begin
                m_live[c] = 1'b0;
            end else begin
                m_k[c]    = m_k[c] + 1;
                m_live[c] = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [CH-1:0] et;
        logic [CH-1:0] ec;
        et = exp_tick();
        ec = exp_clk();
        tests++;
        assert (bus.tick === et) else begin
            fails++;
            $error("FAIL %s tick: got %b expected %b", tag, bus.tick, et);
        end
        tests++;
        assert (bus.newClock === ec) else begin
            fails++;
            $error("FAIL %s newClock: got %b expected %b", tag, bus.newClock, ec);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic do_load(input logic [SW-1:0] sel, input logic [W-1:0] val,
                           input logic mode, input string tag);
        bus.load       = 1'b1;
        bus.load_sel   = sel;
        bus.load_value = val;
        bus.load_mode  = mode;
        step(tag);
        bus.load = 1'b0;
    endtask

    // Asserted between edges so the immediate (asynchronous) clear is visible.
    task automatic apply_reset(input string tag);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_async"});
        @(posedge clk);
        #1;
        check({tag, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        bus.enable     = '0;
        bus.load       = 1'b0;
        bus.load_sel   = '0;
        bus.load_value = '0;
        bus.load_mode  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        rst_n = 1'b1;

        bus.enable = 3'b001;
        run(20, "ch0_default");

        do_load(2'd2, 8'd1, 1'b1, "load_ch2");
        bus.enable[2] = 1'b1;
        run(10, "ch2_pulse");

        bus.enable[0] = 1'b0;
        run(5, "ch0_pause");
        bus.enable[0] = 1'b1;
        run(8, "ch0_resume");

        do_load(2'd1, 8'd0, 1'b0, "load_ch1_d0");
        bus.enable[1] = 1'b1;
        run(8, "ch1_d0");
        do_load(2'd1, 8'd5, 1'b0, "reload_ch1");
        run(14, "ch1_d5");

        do_load(2'd3, W'($urandom), 1'($urandom), "sel_oob");
        run(10, "after_oob");

        do_load(2'd0, 8'd255, 1'b1, "load_max");
        run(260, "ch0_max");

        repeat (400) begin
            bus.enable = CH'($urandom);
            if ($urandom_range(0, 9) == 0)
                do_load(SW'($urandom_range(0, 3)), W'($urandom_range(0, 6)),
                        1'($urandom_range(0, 1)), "rand_load");
            else
                step("rand");
        end

        apply_reset("mid_reset");
        bus.enable = '1;
        run(20, "post_reset_default");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
